t2mi_timestamp_parser: RTL

Upstream stage of the PPS generator. Parses the already clock-domain-synchronized T2-MI byte stream into timestamp fields.
Locates 16-byte timestamp packets (0x47, type 0x20, length 0x000C). Extracts seconds, subseconds and UTC offset, and presents them with a one-cycle strobe to the PPS timing core.
Detects malformed, truncated and stalled packets and reports them. It never emits a bad timestamp.

---
 rtl/t2mi_pkg.sv | 30 +++
 rtl/t2mi_timestamp_parser.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/t2mi_pkg.sv
// Shared constants and enums for the T2-MI timestamp parser.
// Sync/type/length markers, FSM states, error codes, field widths.
package t2mi_pkg;

    localparam logic [7:0]  SYNC_BYTE   = 8'h47;
    localparam logic [7:0]  TS_PKT_TYPE = 8'h20;
    localparam logic [15:0] TS_PKT_LEN  = 16'd12;

    localparam int SEC_W = 40;
    localparam int SUB_W = 32;
    localparam int UTC_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_SKIP
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_LEN     = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_RESYNC  = 3'd3,
        ERR_UTC_RSV = 3'd4
    } err_e;

endpackage

// File: rtl/t2mi_timestamp_parser.sv
// Parses T2-MI timestamp packets into seconds/subseconds/UTC fields.
// Aborts on bad length, stalls, premature sync and reserved UTC bits.
module t2mi_timestamp_parser
    import t2mi_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_sync,
    output logic             ts_valid,
    output logic [SEC_W-1:0] ts_seconds,
    output logic [SUB_W-1:0] ts_subseconds,
    output logic [UTC_W-1:0] ts_utc_offset,
    output logic             pkt_error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam int GAP_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);

    state_e           state;
    logic             ts_pkt;
    logic [7:0]       len_hi;
    logic [3:0]       idx;
    logic [15:0]      remaining;
    logic [GAP_W-1:0] gap_cnt;
    logic [SEC_W-1:0] sec_sh;
    logic [SUB_W-1:0] sub_sh;
    logic [UTC_W-1:0] utc_sh;
    logic             utc_bad;

    logic [15:0] pkt_len;
    logic        sync_hit;

    assign pkt_len  = {len_hi, in_data};
    assign sync_hit = in_valid && in_sync && (in_data == SYNC_BYTE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ts_pkt        <= 1'b0;
            len_hi        <= '0;
            idx           <= '0;
            remaining     <= '0;
            gap_cnt       <= '0;
            sec_sh        <= '0;
            sub_sh        <= '0;
            utc_sh        <= '0;
            utc_bad       <= 1'b0;
            ts_valid      <= 1'b0;
            ts_seconds    <= '0;
            ts_subseconds <= '0;
            ts_utc_offset <= '0;
            pkt_error     <= 1'b0;
            err_code      <= ERR_NONE;
            good_count    <= '0;
            err_count     <= '0;
        end else begin
            ts_valid  <= 1'b0;
            pkt_error <= 1'b0;
            if (state == ST_IDLE) begin
                gap_cnt <= '0;
                if (sync_hit)
                    state <= ST_TYPE;
            end else if (sync_hit) begin
                gap_cnt   <= '0;
                state     <= ST_TYPE;
                pkt_error <= 1'b1;
                err_code  <= ERR_RESYNC;
                if (~&err_count)
                    err_count <= err_count + CNT_W'(1);
            end else if (in_valid) begin
                // Any accepted byte beats a timeout landing in the same cycle.
                gap_cnt <= '0;
                unique case (state)
                    ST_TYPE: begin
                        ts_pkt <= (in_data == TS_PKT_TYPE);
                        state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        len_hi <= in_data;
                        state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        if (ts_pkt) begin
                            if (pkt_len != TS_PKT_LEN) begin
                                state     <= ST_IDLE;
                                pkt_error <= 1'b1;
                                err_code  <= ERR_LEN;
                                if (~&err_count)
                                    err_count <= err_count + CNT_W'(1);
                            end else begin
                                state   <= ST_PAYLOAD;
                                idx     <= '0;
                                utc_bad <= 1'b0;
                            end
                        end else if (pkt_len == 16'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_SKIP;
                            remaining <= pkt_len;
                        end
                    end
                    ST_PAYLOAD: begin
                        idx <= idx + 4'd1;
                        if (idx <= 4'd4)
                            sec_sh <= {sec_sh[SEC_W-9:0], in_data};
                        else if (idx <= 4'd8)
                            sub_sh <= {sub_sh[SUB_W-9:0], in_data};
                        else if (idx == 4'd9) begin
                            utc_sh  <= {in_data[4:0], 8'h00};
                            utc_bad <= |in_data[7:5];
                        end else if (idx == 4'd10)
                            utc_sh[7:0] <= in_data;
                        if (idx == 4'd11) begin
                            state <= ST_IDLE;
                            if (utc_bad) begin
                                pkt_error <= 1'b1;
                                err_code  <= ERR_UTC_RSV;
                                if (~&err_count)
                                    err_count <= err_count + CNT_W'(1);
                            end else begin
                                ts_valid      <= 1'b1;
                                ts_seconds    <= sec_sh;
                                ts_subseconds <= sub_sh;
                                ts_utc_offset <= utc_sh;
                                if (~&good_count)
                                    good_count <= good_count + CNT_W'(1);
                            end
                        end
                    end
                    ST_SKIP: begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (gap_cnt == GAP_LAST) begin
                gap_cnt   <= '0;
                state     <= ST_IDLE;
                pkt_error <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                if (~&err_count)
                    err_count <= err_count + CNT_W'(1);
            end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule
